pentagon_mem_sched: RTL and testbench

Time-slot scheduler sharing the single video/CPU RAM between the video fetch path and the CPU bus interface. A free-running 8-phase slot counter, one character cell of 8 pixel clocks, runs the cycle. Each half-cell window goes either to a video fetch (pixel byte, then attribute byte) or to one CPU access. The block drives the address-mux select, the RAM strobes, the pixel/attribute latch clocks and the shift-register parallel load.

---
 rtl/pentagon_mem_sched_pkg.sv | 24 ++
 rtl/slot_phase_counter.sv | 30 +++
 rtl/pentagon_mem_sched.sv | 186 ++++++++++++++++++
 tb/tb_pentagon_mem_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pentagon_mem_sched_pkg.sv
// Shared types and slot-timing constants for the video/CPU RAM scheduler.
package pentagon_mem_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VFETCH = 2'd1,
        ST_CPU    = 2'd2
    } win_state_e;

    // Cell phases: the two window boundaries and the shift-register load slot.
    localparam logic [2:0] PH_VID  = 3'd0;
    localparam logic [2:0] PH_CPU2 = 3'd4;
    localparam logic [2:0] PH_LOAD = 3'd7;

    // Offsets inside a 4-phase window.
    localparam logic [1:0] PIX_OFS  = 2'd1;
    localparam logic [1:0] ATTR_OFS = 2'd3;
    localparam logic [1:0] ACK_OFS  = 2'd3;

    function automatic logic is_boundary(input logic [2:0] ph);
        return (ph == PH_VID) || (ph == PH_CPU2);
    endfunction

endpackage

// File: rtl/slot_phase_counter.sv
// Free-running 8-phase cell counter; flags window starts and the last phase of a cell.
module slot_phase_counter
    import pentagon_mem_sched_pkg::*;
(
    input  logic       C,
    input  logic       R,
    output logic [2:0] p,
    output logic       win_start,
    output logic       cell_end
);

    logic [2:0] p_q;
    logic [2:0] p_d;

    assign p_d = p_q + 3'd1;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge C) begin
        if (R) begin
            p_q <= 3'd0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p         = p_q;
    assign win_start = is_boundary(p_q);
    assign cell_end  = (p_q == PH_LOAD);

endmodule

// File: rtl/pentagon_mem_sched.sv
// Shared video/CPU RAM slot scheduler: two 4-phase windows per 8-pixel cell,
// each granted to a video fetch, one CPU access, or left idle.
module pentagon_mem_sched
    import pentagon_mem_sched_pkg::*;
#(
    parameter int CPU_AW = 16,
    parameter int VID_AW = 14
) (
    input  logic              C,
    input  logic              R,
    input  logic              vid_active,
    input  logic [VID_AW-1:0] vid_addr_pix,
    input  logic [VID_AW-1:0] vid_addr_attr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic [CPU_AW-1:0] ram_addr,
    input  logic [7:0]        ram_d,
    output logic [7:0]        ram_dout,
    output logic              ram_doe,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              sa,
    output logic              pix_stb,
    output logic              attr_stb,
    output logic              shift_pe
);

    logic [2:0] p;
    logic       win_start;
    logic       cell_end;

    slot_phase_counter u_phase (
        .C         (C),
        .R         (R),
        .p         (p),
        .win_start (win_start),
        .cell_end  (cell_end)
    );

    // Every output is registered, so next-cycle values are built from the next phase.
    logic [2:0] p_nxt;
    logic [1:0] ofs;
    logic [1:0] ofs_nxt;
    logic       bnd_nxt;
    logic       we_phase;

    assign p_nxt    = p + 3'd1;
    assign ofs      = p[1:0];
    assign ofs_nxt  = p_nxt[1:0];
    assign bnd_nxt  = is_boundary(p_nxt);
    // Write strobe spans w+1..w+2, leaving a phase of address/data setup and hold.
    assign we_phase = win_start || (ofs == 2'd1);

    win_state_e        state_q, state_d;
    logic              va_q, va_d;
    logic [CPU_AW-1:0] cmd_addr_q, cmd_addr_d;
    logic              cmd_we_q, cmd_we_d;
    logic [7:0]        cmd_wdata_q, cmd_wdata_d;

    logic              sa_q, sa_d;
    logic [CPU_AW-1:0] ram_addr_q, ram_addr_d;
    logic              ram_oe_n_q, ram_oe_n_d;
    logic              ram_we_n_q, ram_we_n_d;
    logic              ram_doe_q, ram_doe_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              pix_stb_q, pix_stb_d;
    logic              attr_stb_q, attr_stb_d;
    logic              shift_pe_q, shift_pe_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin : next_window
        state_d     = state_q;
        va_d        = cell_end ? vid_active : va_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_we_d    = cmd_we_q;
        cmd_wdata_d = cmd_wdata_q;
        if (bnd_nxt) begin
            if ((p_nxt == PH_VID) && va_d) begin
                state_d = ST_VFETCH;
            end else if (cpu_req) begin
                state_d     = ST_CPU;
                cmd_addr_d  = cpu_addr;
                cmd_we_d    = cpu_we;
                cmd_wdata_d = cpu_wdata;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin : next_outputs
        sa_d        = 1'b0;
        ram_addr_d  = '0;
        ram_oe_n_d  = 1'b1;
        ram_we_n_d  = 1'b1;
        ram_doe_d   = 1'b0;
        ram_dout_d  = 8'h00;
        pix_stb_d   = 1'b0;
        attr_stb_d  = 1'b0;
        cpu_ack_d   = 1'b0;
        shift_pe_d  = (p_nxt == PH_LOAD) && va_q;
        cpu_rdata_d = cpu_rdata_q;
        if ((state_q == ST_CPU) && !cmd_we_q && (ofs == 2'd2)) begin
            cpu_rdata_d = ram_d;
        end
        case (state_d)
            ST_VFETCH: begin
                ram_oe_n_d = 1'b0;
                ram_addr_d = ofs_nxt[1] ? CPU_AW'(vid_addr_attr) : CPU_AW'(vid_addr_pix);
                pix_stb_d  = (ofs_nxt == PIX_OFS);
                attr_stb_d = (ofs_nxt == ATTR_OFS);
            end
            ST_CPU: begin
                sa_d       = 1'b1;
                ram_addr_d = cmd_addr_d;
                cpu_ack_d  = (ofs_nxt == ACK_OFS);
                if (cmd_we_d) begin
                    ram_doe_d  = 1'b1;
                    ram_dout_d = cmd_wdata_d;
                    ram_we_n_d = !we_phase;
                end else begin
                    ram_oe_n_d = bnd_nxt;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q     <= ST_IDLE;
            va_q        <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_we_q    <= 1'b0;
            cmd_wdata_q <= 8'h00;
            sa_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_oe_n_q  <= 1'b1;
            ram_we_n_q  <= 1'b1;
            ram_doe_q   <= 1'b0;
            ram_dout_q  <= 8'h00;
            pix_stb_q   <= 1'b0;
            attr_stb_q  <= 1'b0;
            shift_pe_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            va_q        <= va_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_we_q    <= cmd_we_d;
            cmd_wdata_q <= cmd_wdata_d;
            sa_q        <= sa_d;
            ram_addr_q  <= ram_addr_d;
            ram_oe_n_q  <= ram_oe_n_d;
            ram_we_n_q  <= ram_we_n_d;
            ram_doe_q   <= ram_doe_d;
            ram_dout_q  <= ram_dout_d;
            pix_stb_q   <= pix_stb_d;
            attr_stb_q  <= attr_stb_d;
            shift_pe_q  <= shift_pe_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign sa        = sa_q;
    assign ram_addr  = ram_addr_q;
    assign ram_oe_n  = ram_oe_n_q;
    assign ram_we_n  = ram_we_n_q;
    assign ram_doe   = ram_doe_q;
    assign ram_dout  = ram_dout_q;
    assign pix_stb   = pix_stb_q;
    assign attr_stb  = attr_stb_q;
    assign shift_pe  = shift_pe_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_pentagon_mem_sched.sv
// Randomized bench for pentagon_mem_sched against a cycle-level model of the slot rules.
module tb_pentagon_mem_sched;

    localparam int CPU_AW = 16;
    localparam int VID_AW = 14;

    logic              C = 1'b0;
    logic              R = 1'b1;
    logic              vid_active = 1'b1;
    logic [VID_AW-1:0] vid_addr_pix = 14'h1ABC;
    logic [VID_AW-1:0] vid_addr_attr = 14'h1ABD;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [CPU_AW-1:0] cpu_addr = '0;
    logic [7:0]        cpu_wdata = 8'h00;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack;
    logic [CPU_AW-1:0] ram_addr;
    logic [7:0]        ram_d = 8'h00;
    logic [7:0]        ram_dout;
    logic              ram_doe, ram_oe_n, ram_we_n, sa, pix_stb, attr_stb, shift_pe;

    always #5 C = ~C;

    pentagon_mem_sched #(.CPU_AW(CPU_AW), .VID_AW(VID_AW)) dut (
        .C(C), .R(R), .vid_active(vid_active),
        .vid_addr_pix(vid_addr_pix), .vid_addr_attr(vid_addr_attr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .ram_addr(ram_addr), .ram_d(ram_d),
        .ram_dout(ram_dout), .ram_doe(ram_doe), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .sa(sa), .pix_stb(pix_stb), .attr_stb(attr_stb), .shift_pe(shift_pe)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: current phase, the cell's display flag, and what each window holds.
    typedef enum {W_IDLE, W_VID, W_CPU} win_t;
    int          m_p;
    bit          m_va;
    bit          m_rst;
    win_t        m_win;
    logic [15:0] m_addr;
    bit          m_we;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;

    always @(posedge C) begin
        m_rst <= R;
        if (R) begin
            m_p     <= 0;
            m_va    <= 1'b0;
            m_win   <= W_IDLE;
            m_rdata <= 8'h00;
        end else begin
            m_p <= (m_p + 1) % 8;
            if (m_p == 7) m_va <= vid_active;
            if (m_win == W_CPU && !m_we && (m_p % 4) == 2) m_rdata <= ram_d;
            if (((m_p + 1) % 4) == 0) begin
                if (m_p == 7 && vid_active) begin
                    m_win <= W_VID;
                end else if (cpu_req) begin
                    m_win   <= W_CPU;
                    m_addr  <= cpu_addr;
                    m_we    <= cpu_we;
                    m_wdata <= cpu_wdata;
                end else begin
                    m_win <= W_IDLE;
                end
            end
        end
    end

    task automatic check_cycle();
        int   ofs;
        logic e_sa, e_oe_n, e_we_n, e_doe, e_pix, e_attr, e_ack, e_shift;
        ofs     = m_p % 4;
        e_sa    = 1'b0;
        e_oe_n  = 1'b1;
        e_we_n  = 1'b1;
        e_doe   = 1'b0;
        e_pix   = 1'b0;
        e_attr  = 1'b0;
        e_ack   = 1'b0;
        e_shift = (m_p == 7) && m_va;
        case (m_win)
            W_VID: begin
                e_oe_n = 1'b0;
                e_pix  = (ofs == 1);
                e_attr = (ofs == 3);
                check("ram_addr_vid", 32'(ram_addr),
                      (ofs < 2) ? 32'(vid_addr_pix) : 32'(vid_addr_attr));
            end
            W_CPU: begin
                e_sa  = 1'b1;
                e_ack = (ofs == 3);
                check("ram_addr_cpu", 32'(ram_addr), 32'(m_addr));
                if (m_we) begin
                    e_doe  = 1'b1;
                    e_we_n = !(ofs == 1 || ofs == 2);
                end else begin
                    e_oe_n = (ofs == 0);
                end
            end
            default: begin
            end
        endcase
        check("sa", 32'(sa), 32'(e_sa));
        check("ram_oe_n", 32'(ram_oe_n), 32'(e_oe_n));
        check("ram_we_n", 32'(ram_we_n), 32'(e_we_n));
        check("ram_doe", 32'(ram_doe), 32'(e_doe));
        check("pix_stb", 32'(pix_stb), 32'(e_pix));
        check("attr_stb", 32'(attr_stb), 32'(e_attr));
        check("shift_pe", 32'(shift_pe), 32'(e_shift));
        check("cpu_ack", 32'(cpu_ack), 32'(e_ack));
        if (m_rst) begin
            check("rst_ram_addr", 32'(ram_addr), 32'h0);
            check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        end
        if (e_ack && !m_we) check("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
        if (e_doe) check("ram_dout", 32'(ram_dout), 32'(m_wdata));
    endtask

    int cyc = 0;
    int n_acks = 0;
    int b2b_left = 0;
    int last_ack_cyc = 0;
    int prev_ack_cyc = 0;
    bit ack_now = 1'b0;
    bit rnd_mode = 1'b0;
    bit rnd_ram = 1'b1;

    task automatic new_req_fields();
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom);
        cpu_wdata = 8'($urandom);
    endtask

    // One cycle: sample on the falling edge, then play the requester's side of the handshake.
    task automatic tick();
        @(negedge C);
        cyc++;
        check_cycle();
        ack_now = (cpu_ack === 1'b1);
        if (ack_now) begin
            n_acks++;
            prev_ack_cyc = last_ack_cyc;
            last_ack_cyc = cyc;
            if (rnd_mode) begin
                if ($urandom_range(0, 3) == 0) new_req_fields();
                else cpu_req = 1'b0;
            end else if (b2b_left > 0) begin
                b2b_left--;
            end else begin
                cpu_req = 1'b0;
            end
        end
        if (rnd_ram) ram_d = 8'($urandom);
    endtask

    task automatic wait_phase(input int ph);
        for (int k = 0; k < 16; k++) begin
            tick();
            if (m_p == ph) break;
        end
    endtask

    task automatic wait_ack(input int limit, output int n);
        bit ok;
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            tick();
            n++;
            if (ack_now) begin
                ok = 1'b1;
                break;
            end
        end
        check("ack_timeout", 32'(ok), 32'h1);
    endtask

    initial begin
        int n;
        int a0;

        // Reset state, then the plain video pattern with no CPU traffic.
        for (int k = 0; k < 3; k++) tick();
        R = 1'b0;
        for (int k = 0; k < 24; k++) tick();

        // Active display read, raised at p=1: served in the p=4 window.
        rnd_ram = 1'b0;
        ram_d   = 8'h5A;
        wait_phase(1);
        cpu_we   = 1'b0;
        cpu_addr = 16'h8000;
        cpu_req  = 1'b1;
        wait_ack(20, n);
        check("rd_cycles_incl", 32'(n + 1), 32'd7);
        check("rd_data", 32'(cpu_rdata), 32'h5A);
        rnd_ram = 1'b1;

        // Border write offered at the p=0 boundary.
        vid_active = 1'b0;
        wait_phase(7);
        cpu_we    = 1'b1;
        cpu_addr  = 16'h4000;
        cpu_wdata = 8'hC3;
        cpu_req   = 1'b1;
        wait_ack(20, n);
        check("wr_boundary_to_ack", 32'(n), 32'd4);

        // Back-to-back border reads.
        wait_phase(7);
        cpu_we   = 1'b0;
        cpu_addr = 16'h2222;
        cpu_req  = 1'b1;
        b2b_left = 1;
        wait_ack(20, n);
        wait_ack(20, n);
        check("b2b_gap", 32'(last_ack_cyc - prev_ack_cyc), 32'd4);

        // Reset during w+1 of a write aborts it.
        wait_phase(7);
        cpu_we    = 1'b1;
        cpu_addr  = 16'h4001;
        cpu_wdata = 8'h3C;
        cpu_req   = 1'b1;
        tick();
        tick();
        R       = 1'b1;
        cpu_req = 1'b0;
        tick();
        check("rst_we_n_high", 32'(ram_we_n), 32'h1);
        check("rst_doe_low", 32'(ram_doe), 32'h0);
        tick();
        R  = 1'b0;
        a0 = n_acks;
        for (int k = 0; k < 12; k++) tick();
        check("rst_no_ack", 32'(n_acks - a0), 32'h0);

        // Display switched off mid-cell: next cell's p=0 window goes to the CPU.
        vid_active = 1'b1;
        wait_phase(7);
        wait_phase(7);
        wait_phase(3);
        vid_active = 1'b0;
        wait_phase(5);
        cpu_we   = 1'b0;
        cpu_addr = 16'h1234;
        cpu_req  = 1'b1;
        wait_ack(20, n);
        check("va_toggle_to_ack", 32'(n), 32'd6);

        // Randomized traffic, display toggling and occasional resets.
        rnd_mode = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            tick();
            if ($urandom_range(0, 39) == 0) vid_active = ~vid_active;
            if (!cpu_req && $urandom_range(0, 5) == 0) begin
                new_req_fields();
                cpu_req = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) begin
                R       = 1'b1;
                cpu_req = 1'b0;
                tick();
                vid_addr_pix  = 14'($urandom);
                vid_addr_attr = 14'($urandom);
                tick();
                R = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
